// File: rtl/shift_sub_div.sv
// Sequential signed 16/8 divider: restoring shift-subtract on magnitudes, one quotient bit per clock,
// followed by a sign-fixup cycle. Latency is 17 clocks from the accepting edge to Done.
module shift_sub_div (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] N,
    input  logic [7:0]  D,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Q,
    output logic [7:0]  Rem,
    output logic        DivZero,
    output logic        Ovf
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

    stateT       state, nextState;
    logic [15:0] quo;
    logic [7:0]  dAbs;
    logic [7:0]  partial;
    logic [3:0]  count;
    logic        qNeg, rNeg, zeroOp, ovfOp;

    logic [15:0] nAbsIn;
    logic [7:0]  dAbsIn;
    logic [8:0]  partialShift;
    logic [8:0]  trial;
    logic        fits;

    assign nAbsIn = N[15] ? (16'd0 - N) : N;
    assign dAbsIn = D[7]  ? (8'd0 - D)  : D;

    // quo doubles as the dividend shifter: its MSB feeds the partial remainder while quotient bits enter at the LSB
    assign partialShift = {partial, quo[15]};
    assign trial        = partialShift - {1'b0, dAbs};
    assign fits         = ~trial[8];

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (count == 4'd15) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            quo     <= 16'd0;
            dAbs    <= 8'd0;
            partial <= 8'd0;
            count   <= 4'd0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
            zeroOp  <= 1'b0;
            ovfOp   <= 1'b0;
            Done    <= 1'b0;
            Q       <= 16'd0;
            Rem     <= 8'd0;
            DivZero <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        quo     <= nAbsIn;
                        dAbs    <= dAbsIn;
                        qNeg    <= N[15] ^ D[7];
                        rNeg    <= N[15];
                        zeroOp  <= (D == 8'd0);
                        ovfOp   <= (N == 16'h8000) && (D == 8'hFF);
                        partial <= 8'd0;
                        count   <= 4'd0;
                    end
                end
                RUN: begin
                    // the remainder stays below |D| <= 128, so 8 bits hold it between steps
                    partial <= fits ? trial[7:0] : partialShift[7:0];
                    quo     <= {quo[14:0], fits};
                    count   <= count + 4'd1;
                end
                FIX: begin
                    Done <= 1'b1;
                    if (zeroOp) begin
                        Q       <= 16'd0;
                        Rem     <= 8'd0;
                        DivZero <= 1'b1;
                        Ovf     <= 1'b0;
                    end else if (ovfOp) begin
                        Q       <= 16'h8000;
                        Rem     <= 8'd0;
                        DivZero <= 1'b0;
                        Ovf     <= 1'b1;
                    end else begin
                        Q       <= qNeg ? (16'd0 - quo) : quo;
                        Rem     <= rNeg ? (8'd0 - partial) : partial;
                        DivZero <= 1'b0;
                        Ovf     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
